// File: rtl/mem_clear_pkg.sv
// Shared types and helpers for the memory-clear run sequencer.
// LAST_VEC is handled through a fixed-width carrier, which limits NUM_CH*AW to MCS_VEC_MAX bits.
package mem_clear_pkg;

  localparam int MCS_VEC_MAX = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW,
    VERIFY,
    PROCESS,
    FINISH
  } mcs_state_t;

  // Returns slice c (aw bits wide, aw <= 32) of a packed per-channel vector.
  function automatic logic [31:0] last_addr(input logic [MCS_VEC_MAX-1:0] vec,
                                            input int c, input int aw);
    return 32'(vec >> (c * aw)) & 32'((64'd1 << aw) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_clear_seq_if.sv
// Avalon-MM write-master bundle shared by all clear channels.
interface mem_clear_seq_if #(
  parameter int NUM_CH = 2,
  parameter int AW     = 12,
  parameter int DW     = 32
);
  localparam int BE_W = DW / 8;

  logic [NUM_CH-1:0]    CS;
  logic [NUM_CH-1:0]    WRITE;
  logic [NUM_CH-1:0]    READ;
  logic [NUM_CH*AW-1:0] ADDRESS;
  logic [DW-1:0]        WRITEDATA;
  logic [BE_W-1:0]      BYTE_EN;
  logic [NUM_CH-1:0]    WAIT_REQUEST;

  modport master (output CS, WRITE, READ, ADDRESS, WRITEDATA, BYTE_EN, input WAIT_REQUEST);
  modport slave  (input CS, WRITE, READ, ADDRESS, WRITEDATA, BYTE_EN, output WAIT_REQUEST);
endinterface

// File: rtl/mem_clear_chan.sv
// One clear channel: walks addresses 0..LAST, advancing only on accepted writes.
module mem_clear_chan #(
  parameter int            AW   = 12,
  parameter logic [AW-1:0] LAST = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic          wait_req,
  output logic          cs,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic          done
);

  logic [AW-1:0] cnt;
  logic          done_r;
  logic          accept;

  assign cs     = active & ~done_r;
  assign write  = cs;
  assign addr   = cs ? cnt : '0;
  assign done   = done_r;
  assign accept = write & ~wait_req;

  // Outside the sweep the channel is held cleared so the next sweep starts at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      done_r <= 1'b0;
    end else if (!active) begin
      cnt    <= '0;
      done_r <= 1'b0;
    end else if (accept) begin
      if (cnt == LAST) done_r <= 1'b1;
      else             cnt    <= cnt + AW'(1);
    end
  end

endmodule

// File: rtl/mem_clear_seq.sv
// Run sequencer: clears NUM_CH memories, then DRAW -> VERIFY -> PROCESS -> FINISH.
// Define MCS_RESTART_EN to add the restart port (re-clear from DRAW/VERIFY/PROCESS/FINISH).
module mem_clear_seq
  import mem_clear_pkg::*;
#(
  parameter int                   NUM_CH   = 2,
  parameter int                   AW       = 12,
  parameter int                   DW       = 32,
  parameter logic [NUM_CH*AW-1:0] LAST_VEC = {12'd3839, 12'd959},
  parameter logic [DW-1:0]        FILL     = '0
) (
  input  logic Clk,
  input  logic Reset_n,
`ifdef MCS_RESTART_EN
  input  logic restart,
`endif
  input  logic check,
  input  logic valid,
  input  logic done,
  output logic Run,
  output logic Clean,
  mem_clear_seq_if.master bus
);

  localparam logic [MCS_VEC_MAX-1:0] LAST_EXT = MCS_VEC_MAX'(LAST_VEC);

  mcs_state_t        state, state_nx;
  logic [NUM_CH-1:0] done_vec;
  logic              clear_active;

  assign clear_active  = (state == CLEAR);
  assign bus.READ      = '0;
  assign bus.WRITEDATA = FILL;
  assign bus.BYTE_EN   = '1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    localparam logic [AW-1:0] LAST_C = AW'(last_addr(LAST_EXT, c, AW));

    mem_clear_chan #(
      .AW   (AW),
      .LAST (LAST_C)
    ) u_chan (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .active   (clear_active),
      .wait_req (bus.WAIT_REQUEST[c]),
      .cs       (bus.CS[c]),
      .write    (bus.WRITE[c]),
      .addr     (bus.ADDRESS[c*AW +: AW]),
      .done     (done_vec[c])
    );
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Run      = (state == PROCESS);
    Clean    = (state == CLEAR);
    unique case (state)
      IDLE:    state_nx = CLEAR;
      CLEAR:   if (&done_vec) state_nx = DRAW;
      DRAW:    if (check) state_nx = VERIFY;
      VERIFY:  state_nx = valid ? PROCESS : DRAW;
      PROCESS: if (done) state_nx = FINISH;
      FINISH:  state_nx = FINISH;
      default: state_nx = IDLE;
    endcase
`ifdef MCS_RESTART_EN
    // IDLE and CLEAR ignore restart so no in-flight Avalon write is abandoned.
    if (restart && (state inside {DRAW, VERIFY, PROCESS, FINISH})) state_nx = CLEAR;
`endif
  end

endmodule

// File: tb/tb_mem_clear_seq.sv
// Randomized self-checking bench for mem_clear_seq against a per-channel address scoreboard
// and an abstract run-phase model.
module tb_mem_clear_seq;

  localparam int NUM_CH = 2;
  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int BE_W   = DW / 8;
  localparam int PH_DRAW = 0, PH_VERIFY = 1, PH_PROC = 2, PH_FIN = 3;

  int last_tb [NUM_CH] = '{959, 3839};

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic check = 1'b0, valid = 1'b0, done = 1'b0;
  logic Run, Clean;
`ifdef MCS_RESTART_EN
  logic restart = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int phase  = PH_DRAW;
  int cc;

  mem_clear_seq_if #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW)) bus ();

  mem_clear_seq #(
    .NUM_CH   (NUM_CH),
    .AW       (AW),
    .DW       (DW),
    .LAST_VEC ({12'd3839, 12'd959}),
    .FILL     ('0)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
`ifdef MCS_RESTART_EN
    .restart (restart),
`endif
    .check   (check),
    .valid   (valid),
    .done    (done),
    .Run     (Run),
    .Clean   (Clean),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkIdleBus(input string tag);
    checkOutput({tag, "_clean"}, 64'(Clean), 64'd0);
    checkOutput({tag, "_run"},   64'(Run), 64'd0);
    checkOutput({tag, "_cs"},    64'(bus.CS), 64'd0);
    checkOutput({tag, "_write"}, 64'(bus.WRITE), 64'd0);
    checkOutput({tag, "_addr"},  64'(bus.ADDRESS), 64'd0);
    checkOutput({tag, "_read"},  64'(bus.READ), 64'd0);
    checkOutput({tag, "_be"},    64'(bus.BYTE_EN), 64'((1 << BE_W) - 1));
    checkOutput({tag, "_wdata"}, 64'(bus.WRITEDATA), 64'd0);
  endtask

  task automatic releaseReset();
    check = 1'b0; valid = 1'b0; done = 1'b0;
    bus.WAIT_REQUEST = '0;
    repeat (2) @(negedge Clk);
    checkIdleBus("reset");
    Reset_n = 1'b1;
  endtask

  // mode 0: no stalls; 1: ch1 stalls 3 cycles at address 100; 2: random stalls.
  // abort_at >= 0 pulls reset when ch1 presents that address.
  task automatic runSweep(input int mode, input int abort_at, output int clean_cycles);
    int nxt [NUM_CH];
    int post = 0;
    int stall_left = 3;
    bit all_done, exp_clean, exp_wr;
    logic [NUM_CH-1:0] w;
    clean_cycles = 0;
    for (int c = 0; c < NUM_CH; c++) nxt[c] = 0;
    for (int cyc = 0; cyc <= 20000; cyc++) begin
      if (cyc == 20000) begin
        checkOutput("sweep_timeout", 64'd1, 64'd0);
        break;
      end
      @(negedge Clk);
      all_done = 1'b1;
      for (int c = 0; c < NUM_CH; c++) if (nxt[c] <= last_tb[c]) all_done = 1'b0;
      if (all_done) post++;
      exp_clean = (post < 2);
      checkOutput("sweep_clean", 64'(Clean), 64'(exp_clean));
      checkOutput("sweep_run", 64'(Run), 64'd0);
      if (Clean) clean_cycles++;
      if (!exp_clean) break;
      for (int c = 0; c < NUM_CH; c++) begin
        exp_wr = (nxt[c] <= last_tb[c]);
        checkOutput($sformatf("write%0d", c), 64'(bus.WRITE[c]), 64'(exp_wr));
        checkOutput($sformatf("cs%0d", c), 64'(bus.CS[c]), 64'(exp_wr));
        if (exp_wr)
          checkOutput($sformatf("addr%0d", c), 64'(bus.ADDRESS[c*AW +: AW]), 64'(nxt[c]));
      end
      if (abort_at >= 0 && nxt[1] == abort_at) begin
        Reset_n = 1'b0;
        #1;
        checkIdleBus("abort");
        bus.WAIT_REQUEST = '0;
        return;
      end
      w = '0;
      if (mode == 1 && nxt[1] == 100 && stall_left > 0) begin
        w[1] = 1'b1;
        stall_left--;
      end else if (mode == 2) begin
        for (int c = 0; c < NUM_CH; c++) w[c] = ($urandom_range(3) == 0);
      end
      bus.WAIT_REQUEST = w;
      for (int c = 0; c < NUM_CH; c++)
        if (nxt[c] <= last_tb[c] && !w[c]) nxt[c]++;
    end
    bus.WAIT_REQUEST = '0;
    phase = PH_DRAW;
  endtask

  task automatic applyStimulus(input bit chk, input bit vld, input bit dn);
    int nx;
    check = chk; valid = vld; done = dn;
    case (phase)
      PH_DRAW:   nx = chk ? PH_VERIFY : PH_DRAW;
      PH_VERIFY: nx = vld ? PH_PROC : PH_DRAW;
      PH_PROC:   nx = dn ? PH_FIN : PH_PROC;
      default:   nx = PH_FIN;
    endcase
    @(negedge Clk);
    phase = nx;
    checkOutput("ctl_run", 64'(Run), 64'(phase == PH_PROC));
    checkOutput("ctl_clean", 64'(Clean), 64'd0);
    checkOutput("ctl_cs", 64'(bus.CS), 64'd0);
  endtask

  initial begin
    bus.WAIT_REQUEST = '0;
    releaseReset();

    runSweep(0, -1, cc);
    checkOutput("clear_len_zero_wait", 64'(cc), 64'd3841);

    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom));
    checkOutput("finish_terminal", 64'(phase), 64'(PH_FIN));
    check = 1'b0; valid = 1'b0; done = 1'b0;

`ifdef MCS_RESTART_EN
    restart = 1'b1;
    runSweep(0, -1, cc);
    restart = 1'b0;
    checkOutput("restart_clear_len", 64'(cc), 64'd3841);
    restart = 1'b1; check = 1'b1; valid = 1'b1;
    runSweep(0, -1, cc);
    restart = 1'b0; check = 1'b0; valid = 1'b0;
    checkOutput("restart_prio_len", 64'(cc), 64'd3841);
`endif

    Reset_n = 1'b0;
    #1;
    checkIdleBus("reset2");
    releaseReset();
    runSweep(1, -1, cc);
    checkOutput("clear_len_stall", 64'(cc), 64'd3844);

    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    Reset_n = 1'b0;
    #1;
    checkOutput("async_run_drop", 64'(Run), 64'd0);
    releaseReset();

    runSweep(2, 2000, cc);
    releaseReset();
    runSweep(2, -1, cc);

    for (int i = 0; i < 100; i++)
      applyStimulus($urandom_range(3) == 0, 1'($urandom), $urandom_range(7) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
